// File: rtl/flexbex_ibex_efpga_ctrl.sv
// flexbex_ibex_efpga_ctrl
// Sequences one eFPGA custom instruction from the ID stage. The controller
// latches the opcode and operands and pulses fab_start_o. It then counts a
// fixed latency (delay_i != 0) or waits for fab_done_i (delay_i == 0). It
// captures the fabric result and raises ready_o for one DONE cycle, which
// releases the ID-stage stall.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   en_i, operator_i, operand_*_i ID-stage custom instruction request
//   delay_i                       fixed latency in cycles, 0 = handshake mode
//   kill_i                        pipeline flush, aborts the operation
//   ready_o, busy_o               decoded from the state register
//   result_o, err_o               captured result, watchdog timeout flag
//   fab_start_o, fab_abort_o      one-cycle pulses to the fabric
//   fab_operator_o, fab_operand_* registered request to the fabric
//   fab_result_i, fab_done_i      fabric response
//
// Optional feature: define EFPGA_TIMEOUT_EN to add a handshake-mode watchdog
// of TIMEOUT_CYCLES RUN cycles. Without it, err_o is tied low.

module flexbex_ibex_efpga_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [1:0]  operator_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [3:0]  delay_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic [31:0] result_o,
    output logic        busy_o,
    output logic        err_o,
    output logic        fab_start_o,
    output logic        fab_abort_o,
    output logic [1:0]  fab_operator_o,
    output logic [31:0] fab_operand_a_o,
    output logic [31:0] fab_operand_b_o,
    input  logic [31:0] fab_result_i,
    input  logic        fab_done_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;      // 1: handshake, 0: fixed latency
    logic [31:0] result_q, result_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;

`ifdef EFPGA_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = TIMEOUT_CYCLES[7:0];
    logic [7:0]  wdog_q, wdog_d;      // index of the current RUN cycle, 1-based
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        result_d = result_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        start_d  = 1'b0;
        abort_d  = 1'b0;
`ifdef EFPGA_TIMEOUT_EN
        wdog_d   = wdog_q;
        err_d    = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    op_d    = operator_i;
                    opa_d   = operand_a_i;
                    opb_d   = operand_b_i;
                    cnt_d   = delay_i;
                    mode_d  = (delay_i == 4'd0);
                    start_d = 1'b1;
                    state_d = RUN;
`ifdef EFPGA_TIMEOUT_EN
                    wdog_d  = 8'd1;
                    err_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                if (mode_q) begin
                    if (fab_done_i) begin
                        result_d = fab_result_i;
                        state_d  = DONE;
                    end
`ifdef EFPGA_TIMEOUT_EN
                    else if (wdog_q == TO_LIMIT) begin
                        result_d = 32'd0;
                        err_d    = 1'b1;
                        abort_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        result_d = fab_result_i;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                // en_i still high here belongs to the retiring instruction.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A flush overrides everything above. Only the abort pulse and the
        // error clear are side effects. Data registers keep their values.
        if (kill_i) begin
            state_d  = IDLE;
            start_d  = 1'b0;
            abort_d  = (state_q == RUN);
            cnt_d    = cnt_q;
            mode_d   = mode_q;
            result_d = result_q;
            op_d     = op_q;
            opa_d    = opa_q;
            opb_d    = opb_q;
`ifdef EFPGA_TIMEOUT_EN
            wdog_d   = wdog_q;
            err_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            mode_q   <= 1'b0;
            result_q <= 32'd0;
            op_q     <= 2'd0;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
`ifdef EFPGA_TIMEOUT_EN
            wdog_q   <= 8'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
`ifdef EFPGA_TIMEOUT_EN
            wdog_q   <= wdog_d;
            err_q    <= err_d;
`endif
        end
    end

    assign ready_o         = (state_q != RUN);
    assign busy_o          = (state_q != IDLE);
    assign result_o        = result_q;
    assign fab_start_o     = start_q;
    assign fab_abort_o     = abort_q;
    assign fab_operator_o  = op_q;
    assign fab_operand_a_o = opa_q;
    assign fab_operand_b_o = opb_q;
`ifdef EFPGA_TIMEOUT_EN
    assign err_o           = err_q;
`else
    assign err_o           = 1'b0;
`endif

endmodule

// File: tb/tb_flexbex_ibex_efpga_ctrl.sv
// Bench for flexbex_ibex_efpga_ctrl. Expected results are queued when an
// operation is launched. They are popped and compared in each DONE cycle.
// Cycle-level outputs are checked inline.
`timescale 1ns/1ps

module tb_flexbex_ibex_efpga_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic [1:0]  operator_i = 2'd0;
    logic [31:0] operand_a_i = 32'd0;
    logic [31:0] operand_b_i = 32'd0;
    logic [3:0]  delay_i = 4'd0;
    logic        kill_i = 1'b0;
    logic        ready_o;
    logic [31:0] result_o;
    logic        busy_o;
    logic        err_o;
    logic        fab_start_o;
    logic        fab_abort_o;
    logic [1:0]  fab_operator_o;
    logic [31:0] fab_operand_a_o;
    logic [31:0] fab_operand_b_o;
    logic [31:0] fab_result_i = 32'd0;
    logic        fab_done_i = 1'b0;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q[$];

    flexbex_ibex_efpga_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .en_i            (en_i),
        .operator_i      (operator_i),
        .operand_a_i     (operand_a_i),
        .operand_b_i     (operand_b_i),
        .delay_i         (delay_i),
        .kill_i          (kill_i),
        .ready_o         (ready_o),
        .result_o        (result_o),
        .busy_o          (busy_o),
        .err_o           (err_o),
        .fab_start_o     (fab_start_o),
        .fab_abort_o     (fab_abort_o),
        .fab_operator_o  (fab_operator_o),
        .fab_operand_a_o (fab_operand_a_o),
        .fab_operand_b_o (fab_operand_b_o),
        .fab_result_i    (fab_result_i),
        .fab_done_i      (fab_done_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle. Outputs are stable afterwards, and inputs set now
    // are sampled at the end of this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every DONE cycle retires exactly one queued result.
    always @(negedge clk) begin
        if (!rst && busy_o && ready_o) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            else                   chk("result", result_o, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // ---------------- reset ----------------
        tick(); tick();
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_start", fab_start_o, 0);
        chk("rst_abort", fab_abort_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_op", fab_operator_o, 0);
        chk("rst_opa", fab_operand_a_o, 0);
        chk("rst_opb", fab_operand_b_o, 0);
        rst = 1'b0;
        tick();

        // ---------------- fixed latency, delay 3 ----------------
        en_i = 1; delay_i = 4'd3; operator_i = 2'd1;
        operand_a_i = 32'h12345678; operand_b_i = 32'h9;
        fab_result_i = 32'hDEAD0000;
        exp_q.push_back(32'hCAFEF00D);
        tick(); // T+1
        chk("fix_start", fab_start_o, 1);
        chk("fix_ready1", ready_o, 0);
        chk("fix_busy1", busy_o, 1);
        chk("fix_op", fab_operator_o, 2'd1);
        chk("fix_opa", fab_operand_a_o, 32'h12345678);
        chk("fix_opb", fab_operand_b_o, 32'h9);
        tick(); // T+2
        chk("fix_start2", fab_start_o, 0);
        chk("fix_ready2", ready_o, 0);
        tick(); // T+3
        chk("fix_ready3", ready_o, 0);
        fab_result_i = 32'hCAFEF00D;
        tick(); // T+4 DONE, en still high
        chk("fix_ready4", ready_o, 1);
        chk("fix_busy4", busy_o, 1);
        fab_result_i = 32'hDEAD0001;
        tick(); // T+5 IDLE
        chk("fix_norestart_busy", busy_o, 0);
        chk("fix_norestart_start", fab_start_o, 0);
        en_i = 0;
        tick();
        chk("fix_idle_busy", busy_o, 0);

        // ---------------- handshake ----------------
        en_i = 1; delay_i = 4'd0; operand_a_i = 32'h1; operand_b_i = 32'h2;
        exp_q.push_back(32'h42);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("hs_ready_low", ready_o, 0);
        end
        fab_done_i = 1; fab_result_i = 32'h42;
        tick(); // T+6 DONE
        chk("hs_done_ready", ready_o, 1);
        chk("hs_done_busy", busy_o, 1);
        fab_done_i = 0;
        tick(); // T+7 IDLE, stray done
        en_i = 0; fab_done_i = 1; fab_result_i = 32'h99;
        tick();
        chk("hs_stray_busy", busy_o, 0);
        chk("hs_stray_result", result_o, 32'h42);
`ifndef EFPGA_TIMEOUT_EN
        chk("err_tied", err_o, 0);
`endif
        fab_done_i = 0;
        tick();

        // ---------------- handshake, done in the start cycle ----------------
        en_i = 1; delay_i = 4'd0;
        tick(); // T+1
        fab_done_i = 1; fab_result_i = 32'h77;
        exp_q.push_back(32'h77);
        tick(); // T+2
        chk("hs0_ready", ready_o, 1);
        chk("hs0_busy", busy_o, 1);
        fab_done_i = 0;
        tick();
        en_i = 0;
        chk("hs0_idle", busy_o, 0);
        tick();

        // ---------------- back-to-back, delay 1 ----------------
        en_i = 1; delay_i = 4'd1; operand_a_i = 32'h1; fab_result_i = 32'h1111;
        exp_q.push_back(32'h1111);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("b2b_start", fab_start_o, 32'((k == 1) || (k == 4)));
            if (k == 3) begin
                operand_a_i = 32'h2; fab_result_i = 32'h2222;
                exp_q.push_back(32'h2222);
            end
            if (k == 4) chk("b2b_opa2", fab_operand_a_o, 32'h2);
            if (k == 6) en_i = 0;
        end

        // ---------------- kill in RUN ----------------
        en_i = 1; delay_i = 4'd5; fab_result_i = 32'h5555;
        tick(); // T+1
        chk("kill_start", fab_start_o, 1);
        tick(); // T+2
        kill_i = 1; en_i = 0;
        tick(); // T+3
        chk("kill_abort", fab_abort_o, 1);
        chk("kill_ready", ready_o, 1);
        chk("kill_busy", busy_o, 0);
        chk("kill_result", result_o, 32'h2222);
        kill_i = 0;
        tick();
        chk("kill_abort_pulse", fab_abort_o, 0);

        // ---------------- kill with en in IDLE ----------------
        en_i = 1; kill_i = 1;
        tick();
        chk("killidle_start", fab_start_o, 0);
        chk("killidle_busy", busy_o, 0);
        en_i = 0; kill_i = 0;
        tick();
        chk("killidle_busy2", busy_o, 0);

`ifdef EFPGA_TIMEOUT_EN
        // ---------------- watchdog timeout ----------------
        en_i = 1; delay_i = 4'd0;
        exp_q.push_back(32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("to_ready_low", ready_o, 0);
        end
        tick(); // T+9
        chk("to_done", busy_o & ready_o, 1);
        chk("to_err", err_o, 1);
        chk("to_abort", fab_abort_o, 1);
        tick(); // T+10
        en_i = 0;
        chk("to_err_hold", err_o, 1);
        chk("to_idle", busy_o, 0);
        tick();
        en_i = 1; delay_i = 4'd1; fab_result_i = 32'h3333;
        exp_q.push_back(32'h3333);
        tick();
        chk("to_err_clr", err_o, 0);
        chk("to_restart", fab_start_o, 1);
        tick();
        tick();
        en_i = 0;
        tick();
`endif

        // ---------------- reset mid-RUN ----------------
        en_i = 1; delay_i = 4'd4; operator_i = 2'd3;
        operand_a_i = 32'hAAAA; operand_b_i = 32'hBBBB;
        tick(); // T+1
        tick(); // T+2
        rst = 1; en_i = 0;
        tick(); // T+3
        chk("mrst_ready", ready_o, 1);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_abort", fab_abort_o, 0);
        chk("mrst_start", fab_start_o, 0);
        chk("mrst_result", result_o, 0);
        chk("mrst_opa", fab_operand_a_o, 0);
        chk("mrst_opb", fab_operand_b_o, 0);
        chk("mrst_op", fab_operator_o, 0);
        chk("mrst_err", err_o, 0);
        rst = 0;
        tick();
        tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/flexbex_ibex_efpga_ctrl.md
# flexbex_ibex_efpga_ctrl

Sequencing controller between the ID stage's eFPGA custom-instruction outputs (enable, operator, operands, delay) and the eFPGA fabric port. It latches one custom operation and issues a start pulse to the fabric. It then either counts a fixed latency or waits for a fabric done handshake, captures the result, and drives the ready that releases the ID-stage multicycle stall. The result is consumed by the core's writeback mux as EX data.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: handshake-mode watchdog limit in cycles, 1..255. Only used with EFPGA_TIMEOUT_EN.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- en_i  in  1  eFPGA instruction in ID; held high until the instruction retires
- operator_i  in  2  fabric opcode
- operand_a_i / operand_b_i  in  32  rs1/rs2 data
- delay_i  in  4  fixed latency in cycles; 0 selects handshake mode
- kill_i  in  1  pipeline flush; aborts the operation
- ready_o  out  1  low while an operation is in flight; feeds the EX-ready AND
- result_o  out  32  captured fabric result
- busy_o  out  1  state != IDLE
- err_o  out  1  watchdog timeout flag
- fab_start_o  out  1  one-cycle start pulse
- fab_abort_o  out  1  one-cycle abort pulse
- fab_operator_o  out  2  registered opcode, stable from start until the return to IDLE
- fab_operand_a_o / fab_operand_b_o  out  32  registered operands, stable likewise
- fab_result_i  in  32  fabric result
- fab_done_i  in  1  result-valid strobe, handshake mode only

## Operation
- States:
  - IDLE: ready_o=1.
  - RUN: ready_o=0.
  - DONE: ready_o=1, lasts exactly one cycle.
- IDLE, en_i=1, kill_i=0:
  - Register operator and operands to fab_*_o.
  - Load cnt<=delay_i and mode<=(delay_i==0).
  - Next state RUN. fab_start_o=1 during the first RUN cycle only.
- RUN, fixed mode:
  - cnt decrements each cycle.
  - On the cycle cnt==1: result_o<=fab_result_i, next state DONE.
- RUN, handshake mode:
  - On fab_done_i=1 (including the start cycle): result_o<=fab_result_i, next state DONE.
  - fab_done_i is ignored outside RUN.
- DONE:
  - ready_o=1 lets the ID stage write result_o and retire.
  - Next state is IDLE unconditionally. en_i high in DONE belongs to the retiring instruction and never starts an operation.
- Back-to-back: a new en_i is accepted in the IDLE cycle following DONE.
- kill_i:
  - From any state, next state is IDLE. cnt and result_o keep their values; err_o is cleared.
  - kill_i in RUN also produces fab_abort_o=1 for one cycle.
  - kill_i in IDLE suppresses the start.
  - kill_i takes priority over fab_done_i and over cnt==1.
- Reset values: state IDLE, ready_o=1, busy_o=0, fab_start_o=0, fab_abort_o=0, err_o=0, result_o=0, fab_operator_o=0, fab_operand_*_o=0, cnt=0.
- Outputs are registered, except ready_o and busy_o, which are decoded from the state register.

## Timing
- Cycle T: en_i sampled in IDLE.
- Cycle T+1: RUN, fab_start_o=1.
- Fixed mode, D=delay_i:
  - fab_result_i is sampled at the end of cycle T+D.
  - DONE (ready_o=1) in cycle T+D+1, so the core stall is D+1 cycles.
- Handshake mode:
  - fab_done_i in cycle T+k (k≥1) gives DONE in cycle T+k+1.
- A reset asserted mid-operation returns everything to reset values in the next cycle, with no fab_abort_o pulse.

## Configuration
- EFPGA_TIMEOUT_EN defined:
  - In handshake mode, a watchdog counts RUN cycles from start.
  - If fab_done_i is not seen by the TIMEOUT_CYCLES-th RUN cycle, then in that cycle: result_o<=0, err_o<=1, fab_abort_o=1 next cycle, next state DONE.
  - err_o stays set until the next start or kill_i.
- EFPGA_TIMEOUT_EN undefined:
  - No watchdog logic; handshake mode waits indefinitely.
  - err_o is tied 0.

## Test plan
- Fixed latency: delay_i=3, operands 0x12345678/0x9, fabric result 0xCAFEF00D in the sampled cycle -> fab_start_o in T+1, ready_o low T+1..T+3, high in T+4, result_o=0xCAFEF00D.
- Handshake: delay_i=0, fab_done_i pulsed at T+5 with 0x00000042 -> DONE at T+6, result_o=0x42. A second done pulse at T+7 is ignored.
- Back-to-back: two ops with delay_i=1, en_i held through DONE -> exactly two fab_start_o pulses (T+1 and T+4), no spurious restart in the DONE cycle.
- Kill: kill_i in the second RUN cycle of a delay_i=5 op -> fab_abort_o=1 next cycle, IDLE, ready_o=1, result_o unchanged. Kill in the same cycle as en_i in IDLE -> no start.
- Timeout (with EFPGA_TIMEOUT_EN, TIMEOUT_CYCLES=8): delay_i=0, no fab_done_i -> err_o=1, result_o=0, DONE 9 cycles after start. Next start clears err_o.
- Reset mid-RUN: rst=1 at T+2 -> next cycle all outputs at reset values, ready_o=1, no fab_abort_o.
